// File: rtl/reg_bank_pkg.sv
// Shared definitions for the 8 x 8-bit register bank and its command master.
// The control unit reuses the op codes and the state encoding.
package reg_bank_pkg;

    localparam int unsigned RB_DATA_W = 8;
    localparam int unsigned RB_SEL_W  = 3;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_COPY  = 2'd2;
    localparam logic [1:0] OP_SWAP  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StWrA,
        StWrB
    } rb_state_e;

    // Every op except WRITE begins with a read of the source register.
    function automatic logic op_starts_with_read(logic [1:0] op);
        return op != OP_WRITE;
    endfunction

endpackage

// File: rtl/reg_bank_master.sv
// Command-driven initiator for the register bank: turns READ/WRITE/COPY/SWAP
// commands into single-register bank cycles so multi-register moves are atomic.
module reg_bank_master
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = RB_DATA_W,
    parameter int unsigned SEL_W  = RB_SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_src,
    input  logic [SEL_W-1:0]  cmd_dst,
    input  logic [DATA_W-1:0] cmd_data,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,

    output logic [SEL_W-1:0]  rb_selector,
    output logic [DATA_W-1:0] rb_in_data,
    output logic              rb_write_en,
    output logic              rb_read_en,
    input  logic [DATA_W-1:0] rb_out_data
);

    rb_state_e         state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [SEL_W-1:0]  src_q, src_d;
    logic [SEL_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] t0_q, t0_d;
    logic [DATA_W-1:0] t1_q, t1_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Next-state and operand capture.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        data_d      = data_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    data_d  = cmd_data;
                    state_d = op_starts_with_read(cmd_op) ? StRdA : StWrA;
                end
            end
            StRdA: begin
                t0_d = rb_out_data;
                case (op_q)
                    OP_COPY: state_d = StWrA;
                    OP_SWAP: state_d = StRdB;
                    default: begin
                        state_d     = StIdle;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rb_out_data;
                    end
                endcase
            end
            StRdB: begin
                t1_d    = rb_out_data;
                state_d = StWrA;
            end
            StWrA: begin
                if (op_q == OP_SWAP) begin
                    state_d = StWrB;
                end else begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (op_q == OP_WRITE) ? data_q : t0_q;
                end
            end
            StWrB: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_data_d  = t0_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OP_READ;
            src_q       <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Bank port decodes from state and operand registers only, never from cmd_*.
    always_comb begin
        rb_selector = '0;
        rb_in_data  = '0;
        rb_write_en = 1'b0;
        rb_read_en  = 1'b0;
        case (state_q)
            StRdA: begin
                rb_selector = src_q;
                rb_read_en  = 1'b1;
            end
            StRdB: begin
                rb_selector = dst_q;
                rb_read_en  = 1'b1;
            end
            StWrA: begin
                rb_selector = dst_q;
                rb_in_data  = (op_q == OP_WRITE) ? data_q : t0_q;
                rb_write_en = 1'b1;
            end
            StWrB: begin
                rb_selector = src_q;
                rb_in_data  = t1_q;
                rb_write_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_reg_bank_master.sv
// Directed bench for reg_bank_master driving a behavioural 8 x 8-bit register bank.
module tb_reg_bank_master;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_src;
    logic [2:0] cmd_dst;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [2:0] rb_selector;
    logic [7:0] rb_in_data;
    logic       rb_write_en;
    logic       rb_read_en;
    logic [7:0] rb_out_data;

    logic [7:0] mem [8];
    int tests_run;
    int tests_failed;
    int overlap_cnt;

    reg_bank_master #(
        .DATA_W(8),
        .SEL_W (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rb_selector(rb_selector),
        .rb_in_data (rb_in_data),
        .rb_write_en(rb_write_en),
        .rb_read_en (rb_read_en),
        .rb_out_data(rb_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rb_write_en) mem[rb_selector] <= rb_in_data;
    end
    assign rb_out_data = mem[rb_selector];

    always @(negedge clk) begin
        if (rb_read_en && rb_write_en) overlap_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called one time unit after a rising edge with the master idle; returns
    // latency in cycles from the accept edge plus per-cycle enable/selector traces.
    task automatic send(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                        input logic [7:0] data, output int lat, output logic [7:0] rdata,
                        output logic [15:0] enseq, output logic [23:0] selseq);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat    = 1;
        enseq  = '0;
        selseq = '0;
        while (!rsp_valid && lat < 20) begin
            enseq  = {enseq[13:0], rb_read_en, rb_write_en};
            selseq = {selseq[20:0], rb_selector};
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_data;
    endtask

    int          lat;
    logic [7:0]  rd;
    logic [15:0] en;
    logic [23:0] sel;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        overlap_cnt  = 0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_src   = 3'd0;
        cmd_dst   = 3'd0;
        cmd_data  = 8'h00;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rb_en", {30'd0, rb_read_en, rb_write_en}, 32'd0);
        check_eq("rst_rb_sel", {29'd0, rb_selector}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        check_eq("rst_rb_in", {24'd0, rb_in_data}, 32'd0);

        // WRITE r3 = 0xA5, then READ r3.
        send(2'd1, 3'd0, 3'd3, 8'hA5, lat, rd, en, sel);
        check_eq("wr_lat", lat, 32'd2);
        check_eq("wr_rsp", {24'd0, rd}, 32'hA5);
        check_eq("wr_en_seq", {16'd0, en}, 32'h1);
        check_eq("wr_sel", sel, 32'd3);
        @(posedge clk);
        #1;
        check_eq("rsp_pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check_eq("rsp_data_held", {24'd0, rsp_data}, 32'hA5);
        send(2'd0, 3'd3, 3'd0, 8'h00, lat, rd, en, sel);
        check_eq("rd_lat", lat, 32'd2);
        check_eq("rd_rsp", {24'd0, rd}, 32'hA5);

        // SWAP r1=0x11 <-> r6=0x66.
        send(2'd1, 3'd0, 3'd1, 8'h11, lat, rd, en, sel);
        send(2'd1, 3'd0, 3'd6, 8'h66, lat, rd, en, sel);
        send(2'd3, 3'd1, 3'd6, 8'h00, lat, rd, en, sel);
        check_eq("swap_lat", lat, 32'd5);
        check_eq("swap_rsp", {24'd0, rd}, 32'h11);
        check_eq("swap_en_seq", {16'd0, en}, 32'hA5);
        check_eq("swap_sel_seq", sel, 32'h3B1);
        check_eq("swap_r1", {24'd0, mem[1]}, 32'h66);
        check_eq("swap_r6", {24'd0, mem[6]}, 32'h11);

        // COPY r2=0x3C -> r7.
        send(2'd1, 3'd0, 3'd2, 8'h3C, lat, rd, en, sel);
        send(2'd2, 3'd2, 3'd7, 8'h00, lat, rd, en, sel);
        check_eq("copy_lat", lat, 32'd3);
        check_eq("copy_rsp", {24'd0, rd}, 32'h3C);
        check_eq("copy_en_seq", {16'd0, en}, 32'h9);
        check_eq("copy_r7", {24'd0, mem[7]}, 32'h3C);
        check_eq("copy_r2", {24'd0, mem[2]}, 32'h3C);

        // Back-to-back with cmd_valid held high: WRITE r0=0x01 then READ r0.
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_dst   = 3'd0;
        cmd_src   = 3'd0;
        cmd_data  = 8'h01;
        @(posedge clk);
        #1;
        check_eq("b2b_busy_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("b2b_wr_en", {31'd0, rb_write_en}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("b2b_wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("b2b_ready_in_rsp", {31'd0, cmd_ready}, 32'd1);
        cmd_op   = 2'd0;
        cmd_data = 8'hFF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_eq("b2b_rd_en", {31'd0, rb_read_en}, 32'd1);
        check_eq("b2b_rd_sel", {29'd0, rb_selector}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("b2b_rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("b2b_rd_rsp", {24'd0, rsp_data}, 32'h01);

        // SWAP with src == dst leaves the register unchanged.
        send(2'd1, 3'd0, 3'd4, 8'h44, lat, rd, en, sel);
        send(2'd3, 3'd4, 3'd4, 8'h00, lat, rd, en, sel);
        check_eq("swap_same_lat", lat, 32'd5);
        check_eq("swap_same_rsp", {24'd0, rd}, 32'h44);
        check_eq("swap_same_r4", {24'd0, mem[4]}, 32'h44);

        // Reset during WR_B of SWAP r5=0x55 <-> r7=0x3C.
        send(2'd1, 3'd0, 3'd5, 8'h55, lat, rd, en, sel);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_src   = 3'd5;
        cmd_dst   = 3'd7;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("wrb_en", {31'd0, rb_write_en}, 32'd1);
        check_eq("wrb_sel", {29'd0, rb_selector}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_en", {30'd0, rb_read_en, rb_write_en}, 32'd0);
        check_eq("rst_mid_sel", {29'd0, rb_selector}, 32'd0);
        check_eq("rst_mid_in", {24'd0, rb_in_data}, 32'd0);
        check_eq("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_mid_dst", {24'd0, mem[7]}, 32'h55);
        check_eq("rst_mid_src", {24'd0, mem[5]}, 32'h55);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);

        check_eq("no_enable_overlap", overlap_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_bank_master.md
# reg_bank_master

Command-driven initiator for the 8 x 8-bit register bank: accepts READ, WRITE, COPY and SWAP commands over a valid/ready handshake and sequences them into single-register bank cycles on the bank's selector / data / write-enable / read-enable port. Sits between the control unit and the register bank, so multi-register moves are atomic from the control unit's view.

## Interface
Parameters:
- DATA_W, 8, register width
- SEL_W, 3, register selector width (2^SEL_W registers)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master idle, command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_op  in  2  0 READ, 1 WRITE, 2 COPY, 3 SWAP
- cmd_src  in  SEL_W  source register (READ/COPY/SWAP)
- cmd_dst  in  SEL_W  destination register (WRITE/COPY/SWAP)
- cmd_data  in  DATA_W  write data (WRITE only)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_W  result, held until next rsp_valid
- rb_selector  out  SEL_W  to bank selector
- rb_in_data  out  DATA_W  to bank write data
- rb_write_en  out  1  to bank write enable
- rb_read_en  out  1  to bank read enable
- rb_out_data  in  DATA_W  from bank read data (valid combinationally while rb_read_en)

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B.
- IDLE: cmd_ready=1; on accept latch op/src/dst/data into operand registers.
- READ: IDLE -> RD_A(sel=src) -> IDLE; rsp_data = value read.
- WRITE: IDLE -> WR_A(sel=dst, in_data=cmd_data) -> IDLE; rsp_data = cmd_data.
- COPY: IDLE -> RD_A(src, capture t0) -> WR_A(dst, t0) -> IDLE; rsp_data = t0.
- SWAP: IDLE -> RD_A(src, t0) -> RD_B(dst, t1) -> WR_A(dst, t0) -> WR_B(src, t1) -> IDLE; rsp_data = original src value.
- Read capture: rb_out_data sampled into t0/t1 at the clk edge ending the RD state.
- rb_read_en and rb_write_en never asserted together; both 0 in IDLE with rb_selector=0, rb_in_data=0.
- Bank-side outputs decode only from state and operand registers; no combinational path from cmd_* to rb_*.
- src==dst: COPY and SWAP run full sequence; bank contents unchanged; rsp_data = that register's value.
- Commands presented while busy are ignored (cmd_ready=0); cmd_valid may stay high.

## Timing
- Accept at edge k; first bank cycle is cycle k+1.
- rsp_valid high for exactly one cycle, in the cycle state returns to IDLE: READ/WRITE k+2, COPY k+3, SWAP k+5.
- Bank write takes effect at the edge ending the WR state; a READ accepted in the rsp_valid cycle observes it.
- cmd_ready=1 in the rsp_valid cycle: back-to-back commands, throughput = 1 command per (bank cycles + 1).
- Reset values: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rb_selector=0, rb_in_data=0, rb_write_en=0, rb_read_en=0, t0=t1=0.
- Reset mid-operation: all outputs drop asynchronously; no rsp_valid; a SWAP interrupted after WR_A leaves dst written and src unchanged (not rolled back).

## Structure
- Shared package reg_bank_pkg: DATA_W/SEL_W defaults, op codes (OP_READ, OP_WRITE, OP_COPY, OP_SWAP), state enum; reused by the control unit.
- Single flat FSM module; no sub-module is natural.
- Bench instantiates reg_bank_master driving the existing register bank.

## Test plan
- Reset, then WRITE dst=3 data=0xA5 -> rb_write_en high one cycle with sel=3, rsp_valid at k+2 with rsp_data=0xA5; READ src=3 -> rsp_data=0xA5 at k+2.
- r1=0x11, r6=0x66; SWAP src=1 dst=6 -> enables sequence read,read,write,write; rsp_valid at k+5, rsp_data=0x11; then r1=0x66, r6=0x11.
- r2=0x3C; COPY src=2 dst=7 -> rsp_valid at k+3, rsp_data=0x3C, r7=0x3C, r2 unchanged.
- cmd_valid held high with WRITE r0=0x01 then READ r0 back-to-back -> second accepted in first's rsp_valid cycle, reads 0x01; no overlap of enables.
- SWAP src=dst=4 (r4=0x44) -> r4 still 0x44, rsp_data=0x44.
- Assert rst_n low during SWAP WR_B -> rb_* zero immediately, no rsp_valid, dst holds new value, cmd_ready=1 after release.
